// File: rtl/adder_pkg.sv
// Shared geometry defaults, add/sub mode encoding and the signed-overflow rule for the pipelined adder.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Overflow only when both addends share a sign and the result sign differs from it.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// CHUNK-bit ripple-carry slice; purely combinational (zero latency).
// Holds no state, so backpressure is handled entirely by the enclosing pipeline registers.
module adder_stage #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out
);

  logic [CHUNK:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out = carry[CHUNK];

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract pipelined CHUNK bits per stage; latency WIDTH/CHUNK cycles, one op per cycle.
// A held result (out_valid && !out_ready) freezes every stage and drops in_ready; flush empties the pipe.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int STAGES = (CHUNK < 1) ? 1 : WIDTH / CHUNK;

  if (CHUNK < 1) begin : g_bad_chunk
    $error("pipelined_adder: CHUNK must be at least 1");
  end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
  end

  mode_e            mode;
  logic [WIDTH-1:0] b_eff;
  logic             c_first;
  logic             stall;
  logic             shift;
  logic             accept;

  // Subtraction is a + ~b + 1; a borrow-in cancels that +1, hence c_in ^ sub.
  assign mode    = mode_e'(sub);
  assign b_eff   = (mode == MODE_SUB) ? ~b : b;
  assign c_first = c_in ^ (mode == MODE_SUB);

  assign stall    = out_valid && !out_ready;
  assign shift    = !stall && !flush;
  assign in_ready = shift;
  assign accept   = in_valid && in_ready;

  // Stage k adds chunk k; the operand bits not yet consumed travel alongside in
  // shrinking skew registers, and finished sum chunks accumulate in growing ones.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SRC_W  = WIDTH - k * CHUNK;
    localparam int DONE_W = (k + 1) * CHUNK;

    logic              vld_src;
    logic              cry_src;
    logic [SRC_W-1:0]  a_src;
    logic [SRC_W-1:0]  b_src;
    logic [DONE_W-1:0] s_nxt;
    logic [CHUNK-1:0]  chunk_sum;
    logic              chunk_cout;
    logic              vld_q;
    logic              cry_q;
    logic [DONE_W-1:0] s_q;

    if (k == 0) begin : g_head
      assign vld_src = accept;
      assign cry_src = c_first;
      assign a_src   = a;
      assign b_src   = b_eff;
      assign s_nxt   = chunk_sum;
    end else begin : g_body
      assign vld_src = g_stage[k-1].vld_q;
      assign cry_src = g_stage[k-1].cry_q;
      assign a_src   = g_stage[k-1].g_skew.a_rem_q;
      assign b_src   = g_stage[k-1].g_skew.b_rem_q;
      assign s_nxt   = {chunk_sum, g_stage[k-1].s_q};
    end

    adder_stage #(
      .CHUNK(CHUNK)
    ) u_add (
      .a    (a_src[CHUNK-1:0]),
      .b    (b_src[CHUNK-1:0]),
      .c_in (cry_src),
      .sum  (chunk_sum),
      .c_out(chunk_cout)
    );

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_q <= 1'b0;
        cry_q <= 1'b0;
        s_q   <= '0;
      end else if (flush) begin
        vld_q <= 1'b0;
      end else if (shift) begin
        vld_q <= vld_src;
        cry_q <= chunk_cout;
        s_q   <= s_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [SRC_W-CHUNK-1:0] a_rem_q;
      logic [SRC_W-CHUNK-1:0] b_rem_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else if (shift) begin
          a_rem_q <= a_src[SRC_W-1:CHUNK];
          b_rem_q <= b_src[SRC_W-1:CHUNK];
        end
      end
    end else begin : g_last
      // The top chunk still carries the operand sign bits, so overflow is resolved here.
      logic ovf_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ovf_q <= 1'b0;
        end else if (shift) begin
          ovf_q <= signed_ovf(a_src[CHUNK-1], b_src[CHUNK-1], chunk_sum[CHUNK-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign c_out     = g_stage[STAGES-1].cry_q;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder at WIDTH=8, CHUNK=4 (two stages).
module tb_pipelined_adder;

  localparam int WIDTH = 8;
  localparam int CHUNK = 4;
  localparam int N_RANDOM = 1000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             c_in = 1'b0;
  logic             sub = 1'b0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];

  pipelined_adder #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (op_a),
    .b        (op_b),
    .c_in     (c_in),
    .sub      (sub),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Plain integer arithmetic: unsigned result for sum/carry, signed result for overflow.
  function automatic logic [9:0] ref_result(input logic [7:0] x, input logic [7:0] y,
                                            input logic ci, input logic s);
    int ux, uy, sx, sy, r, sr;
    logic [7:0] res;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    if (s) begin
      r  = ux - uy - int'(ci);
      sr = sx - sy - int'(ci);
      co = (r >= 0);
    end else begin
      r  = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      co = (r >= 256);
    end
    res = r[7:0];
    ov  = (sr > 127) || (sr < -128);
    return {ov, co, res};
  endfunction

  task automatic idle();
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h exp 00", sum); end
    checks++;
    if (c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out got %b exp 0", c_out); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'h00) begin
      errors++; $display("FAIL release_idle got valid=%b sum=%h exp valid=0 sum=00", out_valid, sum);
    end
  endtask

  task automatic test_add_carry();
    @(negedge clk);
    idle();
    in_valid = 1'b1;
    op_a     = 8'hFF;
    op_b     = 8'h01;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %b exp 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b exp 0", out_valid); end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency got valid=%b exp 1", out_valid); end
    checks++;
    if ({overflow, c_out, sum} !== {1'b0, 1'b1, 8'h00}) begin
      errors++; $display("FAIL add_ff_01 got sum=%h c=%b v=%b exp sum=00 c=1 v=0", sum, c_out, overflow);
    end
  endtask

  task automatic test_sub();
    logic [7:0] xa [2];
    logic [7:0] xs [2];
    logic       xc [2];
    logic       xv [2];
    xa = '{8'h80, 8'h00};
    xs = '{8'h7F, 8'hFF};
    xc = '{1'b1, 1'b0};
    xv = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle();
      in_valid = 1'b1;
      sub      = 1'b1;
      op_a     = xa[i];
      op_b     = 8'h01;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || {overflow, c_out, sum} !== {xv[i], xc[i], xs[i]}) begin
        errors++;
        $display("FAIL sub_%0d got valid=%b sum=%h c=%b v=%b exp valid=1 sum=%h c=%b v=%b",
                 i, out_valid, sum, c_out, overflow, xs[i], xc[i], xv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] vs [3];
    int sent = 0;
    int got = 0;
    int nstall = 0;
    va = '{8'h10, 8'h20, 8'h30};
    vb = '{8'h01, 8'h02, 8'h03};
    vs = '{8'h11, 8'h22, 8'h33};
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      @(negedge clk);
      idle();
      out_ready = (cyc >= 3);
      if (sent < 3) begin
        in_valid = 1'b1;
        op_a     = va[sent];
        op_b     = vb[sent];
      end
      #1;
      if (out_valid && !out_ready) begin
        nstall++;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready got %b exp 0", in_ready); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if ({overflow, c_out, sum} !== {2'b00, vs[got]}) begin
          errors++;
          $display("FAIL b2b_result_%0d got sum=%h c=%b v=%b exp sum=%h c=0 v=0", got, sum, c_out, overflow, vs[got]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    checks++;
    if (got != 3 || nstall == 0) begin
      errors++; $display("FAIL b2b_count got results=%0d stalls=%0d exp results=3 stalls>0", got, nstall);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    idle();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op_a      = 8'h05;
    op_b      = 8'h06;
    @(negedge clk);
    op_a = 8'h07;
    op_b = 8'h08;
    @(negedge clk);
    op_a  = 8'h09;
    op_b  = 8'h0A;
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_precond_valid got %b exp 1", out_valid); end
    @(negedge clk);
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drain_%0d got valid=%b exp 0", i, out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op_a      = 8'h12;
    op_b      = 8'h34;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h46) begin
      errors++; $display("FAIL rst_precond got valid=%b sum=%h exp valid=1 sum=46", out_valid, sum);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'h00) begin
      errors++; $display("FAIL rst_immediate got valid=%b sum=%h exp valid=0 sum=00", out_valid, sum);
    end
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_after_%0d got valid=%b exp 0", i, out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] hold_dat = '0;
    logic [9:0] exp_dat;
    exp_q.delete();
    while (got < N_RANDOM && cyc < 20000) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || {overflow, c_out, sum} !== hold_dat) begin
          errors++;
          $display("FAIL rnd_hold got valid=%b dat=%h exp valid=1 dat=%h", out_valid, {overflow, c_out, sum}, hold_dat);
        end
      end
      in_valid  = (sent < N_RANDOM) && ($urandom_range(0, 3) != 0);
      op_a      = 8'($urandom_range(0, 255));
      op_b      = 8'($urandom_range(0, 255));
      c_in      = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      flush     = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++; $display("FAIL rnd_in_ready got %b exp %b", in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected got sum=%h exp no result", sum);
        end else begin
          exp_dat = exp_q.pop_front();
          if ({overflow, c_out, sum} !== exp_dat) begin
            errors++;
            $display("FAIL rnd_result_%0d got sum=%h c=%b v=%b exp sum=%h c=%b v=%b",
                     got, sum, c_out, overflow, exp_dat[7:0], exp_dat[8], exp_dat[9]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_result(op_a, op_b, c_in, sub));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      hold_dat   = {overflow, c_out, sum};
      cyc++;
    end
    checks++;
    if (got != N_RANDOM || exp_q.size() != 0) begin
      errors++; $display("FAIL rnd_count got results=%0d left=%0d exp results=%0d left=0", got, exp_q.size(), N_RANDOM);
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand, sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operands valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH: first operand.
REQ-008 SHALL have port b, input, WIDTH: second operand.
REQ-009 SHALL have port c_in, input, 1: carry-in (add) or borrow-in (sub).
REQ-010 SHALL have port sub, input, 1: 0 = a+b+c_in, 1 = a-b-c_in.
REQ-011 SHALL have port flush, input, 1: synchronous discard of all in-flight operations.
REQ-012 SHALL have port out_valid, output, 1: result valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-014 SHALL have port sum, output, WIDTH: result.
REQ-015 SHALL have port c_out, output, 1: carry-out of MSB; in sub mode 1 = no borrow.
REQ-016 SHALL have port overflow, output, 1: two's-complement signed overflow.

Function
REQ-017 Transfer on input SHALL occur when in_valid && in_ready; on output SHALL occur when out_valid && out_ready.
REQ-018 Datapath SHALL compute a + (sub ? ~b : b) + (c_in ^ sub), modulo 2^WIDTH, c_out = bit WIDTH of that sum.
REQ-019 overflow SHALL be (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), with b_eff = sub ? ~b : b.
REQ-020 Stage k (0..STAGES-1) SHALL add chunk k of a and b_eff with the carry registered by stage k-1 (stage 0 uses c_in ^ sub); higher chunks SHALL be skewed through registers until their stage.
REQ-021 Latency SHALL be exactly STAGES cycles from accept to out_valid, with no stall.
REQ-022 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-023 stall = out_valid && !out_ready; while stall, every stage register SHALL hold and in_ready SHALL be 0.
REQ-024 in_ready SHALL be !stall && !flush, combinational.
REQ-025 flush SHALL clear every stage valid bit on the next edge, override stall, and cause no accept in that cycle; data registers may keep stale values.
REQ-026 Results SHALL emerge in accept order; none dropped or duplicated except by flush or reset.
REQ-027 sum, c_out, overflow SHALL be stable while out_valid && !out_ready.
REQ-028 Bubbles (in_valid = 0) SHALL propagate as invalid stages without affecting neighbours.

Reset
REQ-029 reset low SHALL immediately clear all stage valid bits, carries, skew and result registers to 0.
REQ-030 During and after reset until first accept: out_valid = 0, sum = 0, c_out = 0, overflow = 0; in_ready = 1 once reset is released.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; none appear after release.

Structure
REQ-032 Shared package adder_pkg SHALL hold default WIDTH/CHUNK constants and the mode encoding (MODE_ADD = 0, MODE_SUB = 1).
REQ-033 One sub-module, adder_stage (CHUNK-bit ripple add with carry in/out, combinational), SHALL be instantiated once per stage by generate.
REQ-034 Elaboration SHALL fail if WIDTH % CHUNK != 0 or CHUNK < 1.

Verification (WIDTH=8, CHUNK=4, STAGES=2)
REQ-035 Add 0xFF + 0x01, c_in = 0, out_ready = 1 -> two cycles later out_valid = 1, sum = 0x00, c_out = 1, overflow = 0.
REQ-036 Sub 0x80 - 0x01, c_in = 0 -> sum = 0x7F, c_out = 1, overflow = 1; sub 0x00 - 0x01 -> sum = 0xFF, c_out = 0, overflow = 0.
REQ-037 Accept 0x10+0x01, 0x20+0x02, 0x30+0x03 back-to-back with out_ready = 0 for 3 cycles -> in_ready = 0 while stalled, results 0x11, 0x22, 0x33 in order, none lost.
REQ-038 Two ops in flight, flush = 1 with in_valid = 1 -> in_ready = 0, no out_valid in the following 3 cycles.
REQ-039 reset pulled low with a stalled valid result -> out_valid and sum go to 0 immediately, and nothing emerges after release.
REQ-040 A random 1000-operation stream with random in_valid/out_ready and both modes is checked against a reference model for sum, c_out and overflow, in order.
